// File: rtl/iir_pkg.sv
// Shared types and helpers for the time-multiplexed biquad cascade.
// Holds the FSM state enum, the biquad tap indices and a saturating clamp.
package iir_pkg;

   typedef enum logic [1:0] {IDLE, MAC, UPD, DONE} state_t;

   localparam int TAPS = 5;
   localparam int K_B0 = 0;
   localparam int K_B1 = 1;
   localparam int K_B2 = 2;
   localparam int K_A1 = 3;
   localparam int K_A2 = 4;

   // Wide scratch width for shift/saturate; supports sample widths up to 64.
   localparam int SATW = 128;
   localparam logic signed [SATW-1:0] SAT_ONE = 1;

   // Clamp v to a signed w-bit range; the result is sign-extended to 64 bits.
   function automatic logic signed [63:0] sat(input logic signed [SATW-1:0] v, input int w);
      logic signed [SATW-1:0] mx;
      logic signed [SATW-1:0] mn;
      mx = (SAT_ONE <<< (w - 1)) - SAT_ONE;
      mn = ~mx;
      if (v > mx)      return $signed(mx[63:0]);
      else if (v < mn) return $signed(mn[63:0]);
      else             return $signed(v[63:0]);
   endfunction

endpackage

// File: rtl/iir_mac.sv
// Shared multiply-accumulate for all taps: signed product, clear/negate accumulate,
// and a floor-shift by FRAC saturated back to the sample width.
module iir_mac
   import iir_pkg::*;
#(
   parameter int DW   = 32,
   parameter int CW   = 32,
   parameter int FRAC = 30
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 clr,
   input  logic                 neg,
   input  logic signed [DW-1:0] smp,
   input  logic signed [CW-1:0] cf,
   output logic signed [DW-1:0] y
);

   localparam int PW = DW + CW;
   localparam int AW = PW + 4;

   logic signed [PW-1:0]   sx, cx, prod;
   logic signed [AW-1:0]   pe, acc;
   logic signed [SATW-1:0] shf;

   always_comb begin
      sx   = $signed({{CW{smp[DW-1]}}, smp});
      cx   = $signed({{DW{cf[CW-1]}}, cf});
      prod = sx * cx;
      pe   = $signed({{4{prod[PW-1]}}, prod});
      shf  = $signed({{(SATW-AW){acc[AW-1]}}, acc}) >>> FRAC;
      y    = DW'(sat(shf, DW));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (en) begin
         if (clr) acc <= neg ? -pe : pe;
         else     acc <= neg ? acc - pe : acc + pe;
      end
   end

endmodule

// File: rtl/iir_sos_multich.sv
// NCH-channel cascade of NSEC Direct-Form-I biquads sharing one MAC unit.
// Coefficients are written through a small port and shared by every channel.
module iir_sos_multich
   import iir_pkg::*;
#(
   parameter int DW   = 32,
   parameter int CW   = 32,
   parameter int FRAC = 30,
   parameter int NSEC = 3,
   parameter int NCH  = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NCH*DW-1:0]            audio_in,
   input  logic                         data_val,
   input  logic [2:0]                   scale,
   output logic                         in_ready,
   output logic [NCH*DW-1:0]            audio_out,
   output logic                         audio_out_val,
   input  logic                         coef_we,
   input  logic [$clog2(TAPS*NSEC)-1:0] coef_addr,
   input  logic [CW-1:0]                coef_wdata,
   input  logic                         flush,
   output logic                         overrun,
   input  logic                         clr_flags
);

   localparam int NCF = TAPS * NSEC;
   localparam int CAW = $clog2(NCF);
   localparam int SW  = (NSEC > 1) ? $clog2(NSEC) : 1;
   localparam int HW  = (NCH > 1) ? $clog2(NCH) : 1;

   state_t                            state;
   logic [2:0]                        tap;
   logic [SW-1:0]                     sec;
   logic [HW-1:0]                     ch;
   logic [NCH-1:0][DW-1:0]            in_w, in_q, res_q, out_q, scaled;
   logic [NCH-1:0][NSEC-1:0][DW-1:0]  x1_q, x2_q, y1_q, y2_q;
   logic [NCF-1:0][CW-1:0]            coef_q;
   logic [DW-1:0]                     cur_x;
   logic                              pend_we;
   logic [CAW-1:0]                    pend_addr;
   logic [CW-1:0]                     pend_data;
   logic signed [DW-1:0]              smp, y;
   logic signed [CW-1:0]              cf;

   assign in_w      = audio_in;
   assign audio_out = out_q;
   assign in_ready  = (state == IDLE);

   always_comb begin
      case (int'(tap))
         K_B1:    smp = x1_q[ch][sec];
         K_B2:    smp = x2_q[ch][sec];
         K_A1:    smp = y1_q[ch][sec];
         K_A2:    smp = y2_q[ch][sec];
         default: smp = cur_x;
      endcase
      cf = coef_q[int'(sec) * TAPS + int'(tap)];
   end

   iir_mac #(.DW(DW), .CW(CW), .FRAC(FRAC)) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state == MAC),
      .clr   (int'(tap) == K_B0),
      .neg   (int'(tap) >= K_A1),
      .smp   (smp),
      .cf    (cf),
      .y     (y)
   );

   for (genvar c = 0; c < NCH; c++) begin : g_scale
      logic signed [SATW-1:0] ext;
      always_comb ext = $signed({{(SATW-DW){res_q[c][DW-1]}}, res_q[c]}) <<< scale;
      assign scaled[c] = DW'(sat(ext, DW));
   end

   // A write arriving with a frame strobe is parked until the frame ends, so the
   // frame in flight sees the old coefficient set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coef_q    <= '0;
         pend_we   <= 1'b0;
         pend_addr <= '0;
         pend_data <= '0;
      end else begin
         if (pend_we && (flush || state == DONE)) begin
            coef_q[pend_addr] <= pend_data;
            pend_we           <= 1'b0;
         end
         if (state == IDLE && coef_we && int'(coef_addr) < NCF) begin
            if (data_val && !flush) begin
               pend_we   <= 1'b1;
               pend_addr <= coef_addr;
               pend_data <= coef_wdata;
            end else begin
               coef_q[coef_addr] <= coef_wdata;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         tap           <= '0;
         sec           <= '0;
         ch            <= '0;
         in_q          <= '0;
         res_q         <= '0;
         out_q         <= '0;
         cur_x         <= '0;
         x1_q          <= '0;
         x2_q          <= '0;
         y1_q          <= '0;
         y2_q          <= '0;
         audio_out_val <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         audio_out_val <= 1'b0;
         if (data_val && state != IDLE && !flush) overrun <= 1'b1;
         else if (clr_flags)                      overrun <= 1'b0;

         if (flush) begin
            state <= IDLE;
            tap   <= '0;
            sec   <= '0;
            ch    <= '0;
            x1_q  <= '0;
            x2_q  <= '0;
            y1_q  <= '0;
            y2_q  <= '0;
         end else begin
            case (state)
               IDLE: if (data_val) begin
                  in_q  <= in_w;
                  cur_x <= in_w[0];
                  tap   <= '0;
                  sec   <= '0;
                  ch    <= '0;
                  state <= MAC;
               end
               MAC: begin
                  if (int'(tap) == K_A2) begin
                     tap   <= '0;
                     state <= UPD;
                  end else begin
                     tap <= tap + 3'd1;
                  end
               end
               UPD: begin
                  x1_q[ch][sec] <= cur_x;
                  x2_q[ch][sec] <= x1_q[ch][sec];
                  y1_q[ch][sec] <= y;
                  y2_q[ch][sec] <= y1_q[ch][sec];
                  if (int'(sec) == NSEC - 1) begin
                     res_q[ch] <= y;
                     sec       <= '0;
                     if (int'(ch) == NCH - 1) begin
                        state <= DONE;
                     end else begin
                        ch    <= ch + HW'(1);
                        cur_x <= in_q[int'(ch) + 1];
                        state <= MAC;
                     end
                  end else begin
                     sec   <= sec + SW'(1);
                     cur_x <= y;
                     state <= MAC;
                  end
               end
               DONE: begin
                  out_q         <= scaled;
                  audio_out_val <= 1'b1;
                  state         <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
